// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict: EX-stage branch resolution with a direct-mapped 2-bit predictor read by Fetch.
// Ports: clk/reset (sync, active-high);
//   Fetch read:  PCF -> PredTakenF, PredPCF (combinational)
//   EX resolve:  ValidE, BranchE, JumpE, funct3E, ZeroE, ALUResultE, PCE, PCPlus4E, PCTargetE, PredPCE
//                -> TakenE, MispredictE, RedirectPCE (combinational)
//   Statistics:  BranchCount, MispredictCount (saturating)
module branch_resolve_predict #(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] PCF,
    output logic             PredTakenF,
    output logic [WIDTH-1:0] PredPCF,
    input  logic             ValidE,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic [2:0]       funct3E,
    input  logic             ZeroE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] PCE,
    input  logic [WIDTH-1:0] PCPlus4E,
    input  logic [WIDTH-1:0] PCTargetE,
    input  logic [WIDTH-1:0] PredPCE,
    output logic             TakenE,
    output logic             MispredictE,
    output logic [WIDTH-1:0] RedirectPCE,
    output logic [31:0]      BranchCount,
    output logic [31:0]      MispredictCount
);
    localparam int N = 1 << INDEX_BITS;
    logic             r_valid  [N];
    logic [1:0]       r_ctr    [N];
    logic [WIDTH-1:0] r_target [N];
    logic [31:0]      r_branch_cnt;
    logic [31:0]      r_mis_cnt;
    logic [INDEX_BITS-1:0] w_fidx;
    logic [INDEX_BITS-1:0] w_eidx;
    logic             w_cond;
    logic             w_live;
    logic [1:0]       w_ctr;
    logic [1:0]       w_ctr_next;
    logic [WIDTH-1:0] w_actual;
    logic             w_unused;
    assign w_fidx = PCF[INDEX_BITS+1:2];
    assign w_eidx = PCE[INDEX_BITS+1:2];
    assign PredTakenF = r_valid[w_fidx] & r_ctr[w_fidx][1];
    assign PredPCF = PredTakenF ? r_target[w_fidx] : PCF + WIDTH'(4);
    // funct3[0] inverts the base condition; funct3[2] selects the ALU less-than bit over Zero;
    // 010/011 are not branch encodings and resolve not-taken.
    assign w_cond = funct3E[2] ? (ALUResultE[0] ^ funct3E[0]) : (~funct3E[1] & (ZeroE ^ funct3E[0]));
    assign TakenE = BranchE & w_cond;
    assign w_actual = TakenE ? PCTargetE : PCPlus4E;
    assign RedirectPCE = w_actual;
    assign w_live = ValidE & ~JumpE;
    assign MispredictE = w_live & ~reset & (w_actual != PredPCE);
    assign w_ctr = r_ctr[w_eidx];
    assign w_ctr_next = TakenE ? (&w_ctr ? w_ctr : w_ctr + 2'd1) : (|w_ctr ? w_ctr - 2'd1 : w_ctr);
    assign BranchCount = r_branch_cnt;
    assign MispredictCount = r_mis_cnt;
    assign w_unused = ^{PCF[WIDTH-1:INDEX_BITS+2], PCF[1:0], PCE[WIDTH-1:INDEX_BITS+2], PCE[1:0], ALUResultE[WIDTH-1:1]};
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_valid[i]  <= 1'b0;
                r_ctr[i]    <= 2'b01;
                r_target[i] <= '0;
            end
            r_branch_cnt <= '0;
            r_mis_cnt    <= '0;
        end else begin
            if (w_live & BranchE) begin
                r_valid[w_eidx]  <= 1'b1;
                r_ctr[w_eidx]    <= w_ctr_next;
                r_target[w_eidx] <= PCTargetE;
            end else if (MispredictE) begin
                // a non-branch hit a taken entry of an aliasing branch: drop the entry
                r_valid[w_eidx] <= 1'b0;
            end
            if (w_live & BranchE & ~&r_branch_cnt) r_branch_cnt <= r_branch_cnt + 32'd1;
            if (MispredictE & ~&r_mis_cnt) r_mis_cnt <= r_mis_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_predict.sv
// tb_branch_resolve_predict: directed and randomized checks of branch_resolve_predict against a table model.
module tb_branch_resolve_predict;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF, PredPCF, ALUResultE, PCE, PCPlus4E, PCTargetE, PredPCE, RedirectPCE;
    logic        PredTakenF, ValidE, BranchE, JumpE, ZeroE, TakenE, MispredictE;
    logic [2:0]  funct3E;
    logic [31:0] BranchCount, MispredictCount;
    int n_chk = 0;
    int n_fail = 0;
    bit          m_valid [64];
    int          m_ctr   [64];
    logic [31:0] m_tgt   [64];
    logic [31:0] m_bc, m_mc;

    branch_resolve_predict dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredPCF(PredPCF),
        .ValidE(ValidE), .BranchE(BranchE), .JumpE(JumpE), .funct3E(funct3E), .ZeroE(ZeroE),
        .ALUResultE(ALUResultE), .PCE(PCE), .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE),
        .PredPCE(PredPCE), .TakenE(TakenE), .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
        .BranchCount(BranchCount), .MispredictCount(MispredictCount)
    );

    always #5 clk = ~clk;

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit m_taken();
        if (!BranchE) return 1'b0;
        case (funct3E)
            3'd0: return ZeroE;
            3'd1: return !ZeroE;
            3'd4, 3'd6: return ALUResultE[0];
            3'd5, 3'd7: return !ALUResultE[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_next();
        return m_taken() ? PCTargetE : PCPlus4E;
    endfunction

    function automatic bit m_mis();
        return ValidE && !JumpE && !reset && (m_next() != PredPCE);
    endfunction

    function automatic bit m_pt(input logic [31:0] pc);
        return m_valid[idx(pc)] && m_ctr[idx(pc)] >= 2;
    endfunction

    function automatic logic [31:0] m_ppc(input logic [31:0] pc);
        return m_pt(pc) ? m_tgt[idx(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i] = 1;
            m_tgt[i] = 32'h0;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_model();
        chk("PredTakenF", {31'd0, PredTakenF}, {31'd0, m_pt(PCF)});
        chk("PredPCF", PredPCF, m_ppc(PCF));
        chk("TakenE", {31'd0, TakenE}, {31'd0, m_taken()});
        chk("MispredictE", {31'd0, MispredictE}, {31'd0, m_mis()});
        chk("RedirectPCE", RedirectPCE, m_next());
        chk("BranchCount", BranchCount, m_bc);
        chk("MispredictCount", MispredictCount, m_mc);
    endtask

    task automatic drive(input bit rst, input bit v, input bit b, input bit j, input logic [2:0] f3,
                         input bit z, input bit r0, input logic [31:0] pce, input logic [31:0] tgt,
                         input logic [31:0] ppce, input logic [31:0] pcf);
        reset = rst;
        ValidE = v;
        BranchE = b;
        JumpE = j;
        funct3E = f3;
        ZeroE = z;
        ALUResultE = $urandom();
        ALUResultE[0] = r0;
        PCE = pce;
        PCPlus4E = pce + 32'd4;
        PCTargetE = tgt;
        PredPCE = ppce;
        PCF = pcf;
        #1;
        chk_model();
    endtask

    task automatic tick();
        bit t, mis;
        int i;
        t = m_taken();
        mis = m_mis();
        i = idx(PCE);
        @(posedge clk);
        if (reset) m_reset();
        else if (ValidE && !JumpE) begin
            if (BranchE) begin
                if (m_bc != 32'hFFFF_FFFF) m_bc++;
                m_ctr[i] = t ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
                m_tgt[i] = PCTargetE;
                m_valid[i] = 1'b1;
            end else if (mis) m_valid[i] = 1'b0;
        end
        if (!reset && mis && m_mc != 32'hFFFF_FFFF) m_mc++;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] pcs [5];
        logic [31:0] pce, pcf, tgt, ppce;
        pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h140; pcs[3] = 32'h104; pcs[4] = 32'h300;
        m_reset();
        reset = 1'b1; ValidE = 1'b0; BranchE = 1'b0; JumpE = 1'b0; funct3E = 3'd0; ZeroE = 1'b0;
        ALUResultE = 0; PCE = 0; PCPlus4E = 4; PCTargetE = 0; PredPCE = 0; PCF = 0;
        @(posedge clk);
        @(negedge clk);
        // second reset cycle: live mismatching branch must not redirect or update
        drive(1, 1, 1, 0, 3'd0, 1, 0, 32'h100, 32'h80, 32'h104, 32'h100);
        chk("reset_no_mispredict", {31'd0, MispredictE}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 32'h4, 32'h100);
        chk("reset_pred_taken", {31'd0, PredTakenF}, 32'd0);
        chk("reset_pred_pc", PredPCF, 32'h104);
        chk("reset_bcount", BranchCount, 32'd0);
        chk("reset_mcount", MispredictCount, 32'd0);
        tick();
        // training; Fetch reads the same index in the same cycle and must see the old entry
        drive(0, 1, 1, 0, 3'd0, 1, 0, 32'h100, 32'h80, 32'h104, 32'h100);
        chk("train_taken", {31'd0, TakenE}, 32'd1);
        chk("train_mispredict", {31'd0, MispredictE}, 32'd1);
        chk("train_redirect", RedirectPCE, 32'h80);
        chk("same_cycle_old_entry", {31'd0, PredTakenF}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 32'h4, 32'h100);
        chk("trained_pred_taken", {31'd0, PredTakenF}, 32'd1);
        chk("trained_pred_pc", PredPCF, 32'h80);
        chk("train_bcount", BranchCount, 32'd1);
        chk("train_mcount", MispredictCount, 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 0, 3'd0, 1, 0, 32'h100, 32'h80, 32'h80, 32'h100);
            tick();
        end
        drive(0, 1, 1, 0, 3'd0, 0, 0, 32'h100, 32'h80, 32'h80, 32'h100);
        tick();
        drive(0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 32'h4, 32'h100);
        chk("hysteresis_still_taken", {31'd0, PredTakenF}, 32'd1);
        tick();
        drive(0, 1, 1, 0, 3'd0, 0, 0, 32'h100, 32'h80, 32'h80, 32'h100);
        tick();
        drive(0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 32'h4, 32'h100);
        chk("hysteresis_flip", {31'd0, PredTakenF}, 32'd0);
        tick();
        drive(0, 1, 1, 0, 3'd6, 0, 1, 32'h300, 32'h40, 32'h304, 32'h300);
        chk("bltu_taken", {31'd0, TakenE}, 32'd1);
        tick();
        drive(0, 1, 1, 0, 3'd5, 0, 1, 32'h300, 32'h40, 32'h304, 32'h300);
        chk("bge_not_taken", {31'd0, TakenE}, 32'd0);
        tick();
        drive(0, 1, 1, 0, 3'd1, 1, 1, 32'h300, 32'h40, 32'h304, 32'h300);
        chk("bne_not_taken", {31'd0, TakenE}, 32'd0);
        tick();
        drive(0, 1, 1, 0, 3'd2, 1, 1, 32'h300, 32'h40, 32'h304, 32'h300);
        chk("f3_010_not_taken", {31'd0, TakenE}, 32'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 1, 0, 3'd0, 1, 0, 32'h100, 32'h80, 32'h80, 32'h100);
            tick();
        end
        drive(0, 1, 0, 0, 3'd0, 0, 0, 32'h200, 32'h0, 32'h80, 32'h100);
        chk("alias_mispredict", {31'd0, MispredictE}, 32'd1);
        chk("alias_redirect", RedirectPCE, 32'h204);
        tick();
        drive(0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 32'h4, 32'h100);
        chk("alias_invalidated", {31'd0, PredTakenF}, 32'd0);
        tick();
        drive(0, 0, 1, 0, 3'd0, 1, 0, 32'h100, 32'h80, 32'h999, 32'h100);
        chk("bubble_no_mispredict", {31'd0, MispredictE}, 32'd0);
        tick();
        drive(0, 1, 1, 1, 3'd0, 1, 0, 32'h100, 32'h80, 32'h999, 32'h100);
        chk("jump_no_mispredict", {31'd0, MispredictE}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 32'h4, 32'h100);
        tick();
        for (int k = 0; k < 400; k++) begin
            pce = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pcs[$urandom_range(0, 4)];
            pcf = ($urandom_range(0, 3) == 0) ? pce : pcs[$urandom_range(0, 4)];
            tgt = ($urandom_range(0, 1) == 0) ? 32'h80 : ($urandom() & 32'hFFFF_FFFC);
            case ($urandom_range(0, 3))
                0: ppce = pce + 32'd4;
                1: ppce = tgt;
                2: ppce = $urandom();
                default: ppce = m_ppc(pce);
            endcase
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), pce, tgt, ppce, pcf);
            tick();
        end
        drive(0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 32'h4, 32'h100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_predict.md
# branch_resolve_predict

Execute-stage branch resolution and dynamic predictor for the pipelined RISC-V core. It sits directly downstream of the ALU, consuming the ALU's `Zero` flag and `Result[0]` to decide conditional branches. It compares the actual next PC against the prediction carried down the pipe and raises a redirect on mismatch. It also owns a direct-mapped table of 2-bit saturating counters with branch targets, read combinationally by Fetch to steer the next PC.

## Interface
Parameters:
- `WIDTH`, 32, address/data width.
- `INDEX_BITS`, 6, log2 of table entries (64 entries, index = `PC[INDEX_BITS+1:2]`).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `PCF` in WIDTH: Fetch-stage PC.
- `PredTakenF` out 1: predicted taken for `PCF`.
- `PredPCF` out WIDTH: predicted next PC for `PCF`.
- `ValidE` in 1: EX holds a live instruction this cycle. Upstream guarantees one `ValidE` cycle per instruction; it is low on bubbles and stalls.
- `BranchE` in 1: EX instruction is a conditional branch.
- `JumpE` in 1: EX instruction is jal/jalr, handled elsewhere.
- `funct3E` in 3: branch condition code.
- `ZeroE` in 1: ALU `Zero`.
- `ALUResultE` in WIDTH: ALU result; only bit 0 is used.
- `PCE`, `PCPlus4E`, `PCTargetE` in WIDTH: EX PC, fall-through address, computed branch target.
- `PredPCE` in WIDTH: predicted next PC carried from F.
- `TakenE` out 1: resolved branch outcome.
- `MispredictE` out 1: redirect request.
- `RedirectPCE` out WIDTH: correct next PC.
- `BranchCount`, `MispredictCount` out 32: statistics.

## Operation
- Table entry fields: `valid` (1), `ctr` (2), `target` (WIDTH). All entries are registers, not RAM.
- Reset: every `valid`=0, every `ctr`=2'b01 (weakly not-taken), every `target`=0. `BranchCount`=`MispredictCount`=0.
- Fetch read, combinational:
  - `PredTakenF` = `valid` & `ctr[1]` at index(`PCF`).
  - `PredPCF` = `PredTakenF` ? `target` : `PCF`+4, computed modulo 2^WIDTH.
- Condition decode, active only when `BranchE`:
  - 000 beq → `ZeroE`
  - 001 bne → !`ZeroE`
  - 100 blt and 110 bltu → `ALUResultE[0]`
  - 101 bge and 111 bgeu → !`ALUResultE[0]`
  - 010 and 011 → not taken
  - `TakenE` = 0 when `BranchE`=0.
- Actual next PC = `TakenE` ? `PCTargetE` : `PCPlus4E`.
- `MispredictE` = `ValidE` & !`JumpE` & !`reset` & (actual next PC != `PredPCE`). `RedirectPCE` = actual next PC at all times.
- Table update at the clock edge, when `ValidE` & !`reset`, using index(`PCE`):
  - `BranchE`=1: `ctr` increments if taken, decrements if not. It saturates at 11 and 00. `target` ← `PCTargetE`; `valid` ← 1.
  - `BranchE`=0 & `MispredictE`=1 (aliased entry predicted a non-branch as taken): `valid` ← 0. `ctr` and `target` are unchanged.
  - Otherwise no write.
- Statistics:
  - `BranchCount` increments on `ValidE` & `BranchE`.
  - `MispredictCount` increments on `MispredictE`.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- `JumpE`=1 suppresses mispredict, table update, and both counts.

## Timing
- Prediction has zero latency: `PredTakenF`/`PredPCF` are valid in the same cycle as `PCF`.
- Resolution is combinational: `TakenE`, `MispredictE`, `RedirectPCE` are valid in the same cycle as the EX inputs.
- A table update becomes visible to Fetch on the cycle after the edge that writes it. A same-cycle read and write of one index returns the old entry; there is no bypass.
- Counters update at the edge following the qualifying cycle.
- Reset asserted mid-operation:
  - Table and counters reinitialise at that edge.
  - `MispredictE` is forced 0 while `reset` is high.
  - No update is taken on the reset cycle.
- After reset deassertion, the first prediction for any PC is not-taken, with `PredPCF` = `PCF`+4.

## Test plan
- **Reset:** drive `reset`=1 for 2 cycles, then `PCF`=0x100 → `PredTakenF`=0, `PredPCF`=0x104, both counts 0.
- **Training:** beq at `PCE`=0x100, `ZeroE`=1, `PCTargetE`=0x80, `PredPCE`=0x104, `ValidE`=1:
  - Same cycle: `TakenE`=1, `MispredictE`=1, `RedirectPCE`=0x80.
  - Next cycle, `PCF`=0x100: `PredTakenF`=1, `PredPCF`=0x80.
  - Counts: 1 branch, 1 mispredict.
- **Saturation and hysteresis:**
  - Resolve the same branch taken 4 times → `ctr`=11.
  - Resolve it not-taken once → still predicted taken.
  - Resolve it not-taken a second time → `PredTakenF`=0.
- **Conditions:** bltu with `ALUResultE`=1 → taken; bge with `ALUResultE`=1 → not taken; bne with `ZeroE`=1 → not taken; `funct3E`=010 → not taken.
- **Alias:** train entry at 0x100, then present a non-branch at `PCE`=0x200 (same index) with `PredPCE`=0x80, `PCPlus4E`=0x204:
  - `MispredictE`=1, `RedirectPCE`=0x204.
  - Next cycle, `PCF`=0x100 predicts not-taken.
- **Bubbles, jumps, same-index read/write:**
  - `ValidE`=0 or `JumpE`=1 with a mismatching `PredPCE` → `MispredictE`=0, table and counts unchanged.
  - Simultaneous write and read of one index → old value in that cycle, new value the next cycle.
